// File: rtl/pulse_to_level_stretch_pkg.sv
// Shared types and constants for the pulse-to-level stretcher.
// Holds state encodings, the counter width and the reload helper.
package pulse_to_level_stretch_pkg;

   localparam int PLS_CNT_W  = 22;
   localparam int PLS_PEND_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } plsState_t;

   // A counter loaded with len-1 expires after len cycles; a length of 0 behaves as 1.
   function automatic logic [PLS_CNT_W-1:0] plsLoadValue(input logic [PLS_CNT_W-1:0] len);
      return (len == '0) ? '0 : len - PLS_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pulse_to_level_stretch_if.sv
// Event input and status outputs of the stretcher, bundled for port connection.
// The slave side is the stretcher itself; the master side is whoever drives events.
interface pulse_to_level_stretch_if;
   import pulse_to_level_stretch_pkg::*;

   logic                  pulse;
   logic                  level;
   logic                  busy;
   logic [PLS_PEND_W-1:0] pendingCount;
   logic                  overflow;

   modport master (
      output pulse,
      input  level,
      input  busy,
      input  pendingCount,
      input  overflow
   );

   modport slave (
      input  pulse,
      output level,
      output busy,
      output pendingCount,
      output overflow
   );

endinterface

// File: rtl/pulse_to_level_stretch_counter.sv
// Loadable down-counter with a zero flag; it never wraps below zero.
// A single instance times both the hold window and the low gap.
module pls_down_counter
   import pulse_to_level_stretch_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [PLS_CNT_W-1:0] loadValue_i,
   input  logic                 dec_i,
   output logic                 zero_o
);

   logic [PLS_CNT_W-1:0] count_q;
   logic [PLS_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadValue_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - PLS_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_to_level_stretch.sv
// Turns rising edges on the pulse input into fixed-width high windows separated by low gaps,
// queueing edges that arrive while busy (or extending the window in retrigger mode).
module pulse_to_level_stretch
   import pulse_to_level_stretch_pkg::*;
#(
   parameter logic [PLS_CNT_W-1:0] Hold_Length = 22'd2500000,
   parameter logic [PLS_CNT_W-1:0] Gap_Length  = 22'd2500000,
   parameter logic                 Retrigger   = 1'b0,
   parameter logic [2:0]           Queue_Depth = 3'd4
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   pulse_to_level_stretch_if.slave  bus
);

   localparam logic [PLS_CNT_W-1:0] HOLD_LOAD = plsLoadValue(Hold_Length);
   localparam logic [PLS_CNT_W-1:0] GAP_LOAD  = plsLoadValue(Gap_Length);

   plsState_t             state_q, state_d;
   logic [PLS_PEND_W-1:0] pending_q, pending_d;
   logic                  overflow_q, overflow_d;
   logic                  level_q, level_d;
   logic                  pulse_q;

   logic                  evt;
   logic                  queueFull;
   logic                  exitToHigh;
   logic [PLS_PEND_W-1:0] exitPending;

   logic                  cntLoad;
   logic [PLS_CNT_W-1:0]  cntLoadValue;
   logic                  cntDec;
   logic                  cntZero;

   // The edge register keeps following the input during reset, so a level held
   // across reset release is not seen as a fresh event.
   always_ff @(posedge clk_i) begin
      pulse_q <= bus.pulse;
   end

   assign evt        = bus.pulse & ~pulse_q;
   assign queueFull  = (pending_q == Queue_Depth);
   assign exitToHigh = (pending_q != '0) || evt;
   assign exitPending = ((pending_q != '0) && !evt) ? pending_q - PLS_PEND_W'(1) : pending_q;

   pls_down_counter uCounter (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (cntLoad),
      .loadValue_i (cntLoadValue),
      .dec_i       (cntDec),
      .zero_o      (cntZero)
   );

   // Next-state logic; a fresh edge on the last gap cycle with a non-empty queue is a
   // push and a pop at once, so the count is left alone while the next window starts.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      overflow_d   = 1'b0;
      cntLoad      = 1'b0;
      cntLoadValue = HOLD_LOAD;
      cntDec       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (evt) begin
               state_d = ST_HIGH;
               cntLoad = 1'b1;
            end
         end

         ST_HIGH: begin
            if (evt && Retrigger) begin
               cntLoad = 1'b1;
            end else if (cntZero && (Gap_Length == '0)) begin
               if (exitToHigh) begin
                  cntLoad   = 1'b1;
                  pending_d = exitPending;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (evt) begin
                  if (queueFull) overflow_d = 1'b1;
                  else           pending_d  = pending_q + PLS_PEND_W'(1);
               end
               if (cntZero) begin
                  state_d      = ST_GAP;
                  cntLoad      = 1'b1;
                  cntLoadValue = GAP_LOAD;
               end else begin
                  cntDec = 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (cntZero) begin
               if (exitToHigh) begin
                  state_d   = ST_HIGH;
                  cntLoad   = 1'b1;
                  pending_d = exitPending;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cntDec = 1'b1;
               if (evt) begin
                  if (queueFull) overflow_d = 1'b1;
                  else           pending_d  = pending_q + PLS_PEND_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      level_d = (state_d == ST_HIGH);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         level_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         level_q    <= level_d;
      end
   end

   assign bus.level        = level_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.pendingCount = pending_q;
   assign bus.overflow     = overflow_q;

endmodule
